// File: rtl/wb_pkg.sv
// Shared types and constants for the register writeback stage.
// Purely declarative: no logic, no latency.
// Backpressure: n/a.
package wb_pkg;

    // Half-word write enables for the register file port
    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_LO   = 2'b01;
    localparam logic [1:0] WE_HI   = 2'b10;
    localparam logic [1:0] WE_FULL = 2'b11;

    // Register encoding width (8 architectural registers)
    localparam int RENC_W = 3;

    // Load assembler states
    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LO   = 2'd1,
        LD_HI   = 2'd2,
        LD_DONE = 2'd3
    } ld_state_e;

    // One queued execute result
    typedef struct packed {
        logic [RENC_W-1:0] rd;
        logic [1:0]        we;
        logic [31:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// Synchronous DEPTH-entry FIFO of execute results with per-slot rd/valid export.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module wb_queue
    import wb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  wb_entry_t                 push_dat,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH*RENC_W-1:0]   ent_rd,
    output logic [DEPTH-1:0]          ent_vld
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage; contents are don't-care until the slot is counted valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    // A slot is live when its distance from the read pointer is below the count
    always_comb begin
        logic [PTR_W-1:0] off;
        off     = '0;
        ent_rd  = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - rd_ptr_q;
            ent_vld[i] = (CNT_W'(off) < count_q);
            ent_rd[i*RENC_W +: RENC_W] = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: queues execute results, assembles 16-bit load beats, drives the RF write port.
// Latency: execute result written 1 cycle after acceptance; load written 1 cycle after final beat.
// Backpressure: ex_ready low when the queue is full; a finished load stalls the queue head one cycle.
// Optional: WB_LD_SEXT_EN makes 16-bit loads sign-extend instead of zero-extend.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [2:0]        ex_rd,
    input  logic [1:0]        ex_we,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ld_start,
    input  logic [2:0]        ld_rd,
    input  logic              ld_word,
    output logic              ld_busy,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic [1:0]        rf_we,
    output logic [2:0]        rf_wenc,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [7:0]        pend_mask
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ld_state_e           state_q;
    logic [RENC_W-1:0]   ld_rd_q;
    logic                ld_word_q;
    logic [31:0]         ld_data_q;

    logic [1:0]          rf_we_q;
    logic [RENC_W-1:0]   rf_wenc_q;
    logic [DATA_W-1:0]   rf_wdata_q;

    wb_entry_t           q_push_dat;
    wb_entry_t           q_head;
    logic [CNT_W-1:0]    q_count;
    logic                q_full;
    logic                q_empty;
    logic                q_push;
    logic                q_pop;
    logic [DEPTH*RENC_W-1:0] q_ent_rd;
    logic [DEPTH-1:0]    q_ent_vld;
    logic [15:0]         short_ext;

    // Zero-enable results are accepted but never occupy a slot
    assign ex_ready   = !reset && (q_count < CNT_W'(DEPTH));
    assign q_push     = ex_valid && !reset && !q_full && (ex_we != WE_NONE);
    assign q_pop      = !q_empty && (state_q != LD_DONE);
    assign q_push_dat = '{rd: ex_rd, we: ex_we, data: ex_data};
    assign ld_busy    = (state_q != LD_IDLE);

    assign rf_we    = rf_we_q;
    assign rf_wenc  = rf_wenc_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_LD_SEXT_EN
    assign short_ext = {16{mem_rdata[15]}};
`else
    assign short_ext = 16'h0000;
`endif

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .head     (q_head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty),
        .ent_rd   (q_ent_rd),
        .ent_vld  (q_ent_vld)
    );

    // Load assembler: collects one or two 16-bit beats into a full-width result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LD_IDLE;
            ld_rd_q   <= '0;
            ld_word_q <= 1'b0;
            ld_data_q <= '0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (ld_start) begin
                        ld_rd_q   <= ld_rd;
                        ld_word_q <= ld_word;
                        state_q   <= LD_LO;
                    end
                end
                LD_LO: begin
                    if (mem_rvalid) begin
                        ld_data_q[15:0] <= mem_rdata;
                        if (ld_word_q) begin
                            state_q <= LD_HI;
                        end else begin
                            ld_data_q[31:16] <= short_ext;
                            state_q          <= LD_DONE;
                        end
                    end
                end
                LD_HI: begin
                    if (mem_rvalid) begin
                        ld_data_q[31:16] <= mem_rdata;
                        state_q          <= LD_DONE;
                    end
                end
                LD_DONE: state_q <= LD_IDLE;
                default: state_q <= LD_IDLE;
            endcase
        end
    end

    // Write-port arbitration: finished load first, then queue head; encoding/data hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= WE_NONE;
            rf_wenc_q  <= '0;
            rf_wdata_q <= '0;
        end else if (state_q == LD_DONE) begin
            rf_we_q    <= WE_FULL;
            rf_wenc_q  <= ld_rd_q;
            rf_wdata_q <= DATA_W'(ld_data_q);
        end else if (!q_empty) begin
            rf_we_q    <= q_head.we;
            rf_wenc_q  <= q_head.rd;
            rf_wdata_q <= DATA_W'(q_head.data);
        end else begin
            rf_we_q <= WE_NONE;
        end
    end

    // Outstanding writes: queued entries, in-flight load, and the write committing this cycle
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_ent_vld[i]) pend_mask[q_ent_rd[i*RENC_W +: RENC_W]] = 1'b1;
        end
        if (state_q != LD_IDLE)  pend_mask[ld_rd_q]   = 1'b1;
        if (rf_we_q != WE_NONE)  pend_mask[rf_wenc_q] = 1'b1;
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
// Build with WB_LD_SEXT_EN defined to match a sign-extending DUT.
module tb_reg_writeback;

    localparam int DEPTH = 2;

    typedef struct {
        logic [2:0]  rd;
        logic [1:0]  we;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_rd;
    logic [1:0]  ex_we;
    logic [31:0] ex_data;
    logic        ld_start;
    logic [2:0]  ld_rd;
    logic        ld_word;
    logic        ld_busy;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [1:0]  rf_we;
    logic [2:0]  rf_wenc;
    logic [31:0] rf_wdata;
    logic [7:0]  pend_mask;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    ent_t        mq[$];
    bit          m_busy, m_done, m_word;
    int          m_got;
    logic [2:0]  m_rd;
    logic [31:0] m_val;
    logic [1:0]  e_we;
    logic [2:0]  e_wenc;
    logic [31:0] e_wdata;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_we      (ex_we),
        .ex_data    (ex_data),
        .ld_start   (ld_start),
        .ld_rd      (ld_rd),
        .ld_word    (ld_word),
        .ld_busy    (ld_busy),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_wenc    (rf_wenc),
        .rf_wdata   (rf_wdata),
        .pend_mask  (pend_mask)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] short_upper(input logic [15:0] beat);
`ifdef WB_LD_SEXT_EN
        return beat[15] ? 16'hFFFF : 16'h0000;
`else
        return 16'h0000;
`endif
    endfunction

    // Advance the model by one rising edge using the inputs the DUT just sampled
    task automatic model_edge();
        int   pre;
        ent_t h;
        pre = mq.size();
        if (reset) begin
            mq.delete();
            m_busy  = 0;
            m_done  = 0;
            m_got   = 0;
            e_we    = 2'b00;
            e_wenc  = 3'd0;
            e_wdata = 32'd0;
            return;
        end
        if (m_done) begin
            e_we = 2'b11; e_wenc = m_rd; e_wdata = m_val;
        end else if (pre > 0) begin
            h = mq.pop_front();
            e_we = h.we; e_wenc = h.rd; e_wdata = h.data;
        end else begin
            e_we = 2'b00;
        end
        if (ex_valid && pre < DEPTH && ex_we != 2'b00)
            mq.push_back('{rd: ex_rd, we: ex_we, data: ex_data});
        if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            if (mem_rvalid) begin
                if (m_got == 0) m_val = {m_word ? m_val[31:16] : short_upper(mem_rdata), mem_rdata};
                else            m_val[31:16] = mem_rdata;
                m_got++;
                if (m_got == (m_word ? 2 : 1)) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end else if (ld_start) begin
            m_busy = 1; m_got = 0; m_rd = ld_rd; m_word = ld_word; m_val = 32'd0;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] pm;
        pm = 8'd0;
        foreach (mq[i]) pm[mq[i].rd] = 1'b1;
        if (m_busy || m_done) pm[m_rd] = 1'b1;
        if (e_we != 2'b00) pm[e_wenc] = 1'b1;
        chk("ex_ready",  32'(ex_ready),  32'(!reset && mq.size() < DEPTH));
        chk("ld_busy",   32'(ld_busy),   32'(m_busy || m_done));
        chk("rf_we",     32'(rf_we),     32'(e_we));
        chk("rf_wenc",   32'(rf_wenc),   32'(e_wenc));
        chk("rf_wdata",  rf_wdata,       e_wdata);
        chk("pend_mask", 32'(pend_mask), 32'(pm));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_rd = 0; ex_we = 0; ex_data = 0;
        ld_start = 0; ld_rd = 0; ld_word = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        @(negedge clk);
        chk("ex_ready_in_reset", 32'(ex_ready), 32'd0);
        step(); step();
        reset = 0;
        step();
        chk("ready_after_reset", 32'(ex_ready), 32'd1);
        chk("pend_after_reset",  32'(pend_mask), 32'd0);

        // Single execute write
        ex_valid = 1; ex_rd = 3; ex_we = 2'b11; ex_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        chk("dbeef_pend_accept", 32'(pend_mask[3]), 32'd1);
        step();
        chk("dbeef_we",   32'(rf_we), 32'd3);
        chk("dbeef_data", rf_wdata, 32'hDEADBEEF);
        chk("dbeef_pend_write", 32'(pend_mask[3]), 32'd1);
        step();
        chk("dbeef_once", 32'(rf_we), 32'd0);

        // Three back-to-back pushes into a two-deep queue, held while a load blocks the drain
        ld_start = 1; ld_rd = 7; ld_word = 0;
        step();
        ld_start = 0;
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1; ex_rd = 3'(i + 1); ex_we = 2'b11; ex_data = 32'h1000 + 32'(i);
            if (i == 1) begin mem_rvalid = 1; mem_rdata = 16'h0042; end
            else mem_rvalid = 0;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        // 32-bit load with a gap between beats
        ld_start = 1; ld_rd = 5; ld_word = 1;
        step();
        ld_start = 0;
        chk("ld32_busy_start", 32'(ld_busy), 32'd1);
        mem_rvalid = 1; mem_rdata = 16'h1234; step();
        mem_rvalid = 0; step(); step();
        mem_rvalid = 1; mem_rdata = 16'hABCD; step();
        mem_rvalid = 0;
        step();
        chk("ld32_data", rf_wdata, 32'hABCD1234);
        chk("ld32_we",   32'(rf_we), 32'd3);
        chk("ld32_busy_fall", 32'(ld_busy), 32'd0);

        // 16-bit load finishing while an execute result waits
        ld_start = 1; ld_rd = 2; ld_word = 0;
        step();
        ld_start = 0;
        mem_rvalid = 1; mem_rdata = 16'h8001;
        ex_valid = 1; ex_rd = 6; ex_we = 2'b01; ex_data = 32'h0000_5555;
        step();
        idle_inputs();
        step();
`ifdef WB_LD_SEXT_EN
        chk("ld16_data", rf_wdata, 32'hFFFF8001);
`else
        chk("ld16_data", rf_wdata, 32'h00008001);
`endif
        chk("ld16_first_wenc", 32'(rf_wenc), 32'd2);
        step();
        chk("queued_after_ld", 32'(rf_wenc), 32'd6);
        chk("queued_we", 32'(rf_we), 32'd1);

        // Reset between load beats
        ld_start = 1; ld_rd = 4; ld_word = 1;
        step();
        ld_start = 0;
        mem_rvalid = 1; mem_rdata = 16'h7777; step();
        mem_rvalid = 0; reset = 1; step();
        reset = 0;
        chk("rst_mid_busy", 32'(ld_busy), 32'd0);
        chk("rst_mid_pend", 32'(pend_mask), 32'd0);
        mem_rvalid = 1; mem_rdata = 16'h9999; step();
        mem_rvalid = 0; step();
        chk("stray_beat_no_write", 32'(rf_we), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 149) == 0);
            ex_valid   = $urandom_range(0, 1);
            ex_rd      = 3'($urandom);
            ex_we      = 2'($urandom);
            ex_data    = $urandom;
            ld_start   = ($urandom_range(0, 3) == 0);
            ld_rd      = 3'($urandom);
            ld_word    = $urandom_range(0, 1);
            mem_rvalid = $urandom_range(0, 1);
            mem_rdata  = 16'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
